jt12_wr_sched: RTL and testbench

Write scheduler between the CPU bus interface and the FM register file. It latches register-address and data writes, then decodes the target register into a channel/operator selector and a one-hot update strobe. It holds that request stable for one full operator round so the register file's slot-matched update logic finds its slot. While a request is held it reports busy, and data writes arriving then are dropped and flagged.

---
 rtl/jt12_wr_pkg.sv | 45 ++++
 rtl/jt12_wr_dec.sv | 54 +++++
 rtl/jt12_wr_sched.sv | 167 ++++++++++++++++
 tb/tb_jt12_wr_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_wr_pkg.sv
// Shared constants and types for the jt12 write scheduler.
package jt12_wr_pkg;

  // Register addresses and operator group nibbles (sel[7:4])
  localparam logic [7:0] REG_KEYON  = 8'h28;
  localparam logic [3:0] GRP_DT1    = 4'h3;
  localparam logic [3:0] GRP_TL     = 4'h4;
  localparam logic [3:0] GRP_KS_AR  = 4'h5;
  localparam logic [3:0] GRP_AMEN_DR = 4'h6;
  localparam logic [3:0] GRP_SR     = 4'h7;
  localparam logic [3:0] GRP_SL_RR  = 4'h8;
  localparam logic [3:0] GRP_SSGEG  = 4'h9;
  localparam logic [7:0] REG_FNUMLO = 8'hA0;
  localparam logic [7:0] REG_FNUMHI = 8'hA4;
  localparam logic [7:0] REG_ALG    = 8'hB0;
  localparam logic [7:0] REG_PMS    = 8'hB4;

  localparam int unsigned NUM_STB = 11;

  typedef enum logic {
    IDLE,
    HOLD
  } wr_state_e;

  // Bit positions inside the one-hot strobe vector
  typedef enum logic [3:0] {
    STB_KEYON   = 4'd0,
    STB_DT1     = 4'd1,
    STB_TL      = 4'd2,
    STB_KS_AR   = 4'd3,
    STB_AMEN_DR = 4'd4,
    STB_SR      = 4'd5,
    STB_SL_RR   = 4'd6,
    STB_SSGEG   = 4'd7,
    STB_ALG     = 4'd8,
    STB_FNUMLO  = 4'd9,
    STB_PMS     = 4'd10
  } stb_idx_e;

  // One operator round: 4 operators per channel, in clk_en slots
  function automatic logic [4:0] round_len(input int unsigned nch);
    return (nch == 3) ? 5'd12 : 5'd24;
  endfunction

endpackage

// File: rtl/jt12_wr_dec.sv
// Combinational decode of the latched register address into a one-hot
// update strobe plus channel/operator selector.
module jt12_wr_dec
  import jt12_wr_pkg::*;
#(
  parameter int unsigned num_ch = 6
) (
  input  logic               part,
  input  logic [7:0]         sel,
  output logic [NUM_STB-1:0] stb,
  output logic [2:0]         ch,
  output logic [1:0]         op,
  output logic               valid,
  output logic               latch
);

  logic part_ok;

  // Part 1 only exists on 6-channel chips; slot 3 of a group is unused.
  assign part_ok = !(part && (num_ch == 3));

  // Address decode
  always_comb begin
    stb   = '0;
    latch = 1'b0;
    ch    = {part, sel[1:0]};
    op    = sel[3:2];
    if (part_ok && (sel[1:0] != 2'd3)) begin
      case (sel[7:4])
        4'h2: begin
          if (sel == REG_KEYON && !part) stb[STB_KEYON] = 1'b1;
        end
        GRP_DT1:     stb[STB_DT1]     = 1'b1;
        GRP_TL:      stb[STB_TL]      = 1'b1;
        GRP_KS_AR:   stb[STB_KS_AR]   = 1'b1;
        GRP_AMEN_DR: stb[STB_AMEN_DR] = 1'b1;
        GRP_SR:      stb[STB_SR]      = 1'b1;
        GRP_SL_RR:   stb[STB_SL_RR]   = 1'b1;
        GRP_SSGEG:   stb[STB_SSGEG]   = 1'b1;
        4'hA: begin
          if (sel[3:2] == REG_FNUMLO[3:2]) stb[STB_FNUMLO] = 1'b1;
          else if (sel[3:2] == REG_FNUMHI[3:2]) latch = 1'b1;
        end
        4'hB: begin
          if (sel[3:2] == REG_ALG[3:2]) stb[STB_ALG] = 1'b1;
          else if (sel[3:2] == REG_PMS[3:2]) stb[STB_PMS] = 1'b1;
        end
        default: ;
      endcase
    end
    valid = |stb;
  end

endmodule

// File: rtl/jt12_wr_sched.sv
// Write scheduler: latches CPU writes, decodes them and holds the resulting
// update request for one operator round so the slot-matched register file
// can pick it up.
module jt12_wr_sched
  import jt12_wr_pkg::*;
#(
  parameter int unsigned num_ch = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  input  logic       write,
  output logic       busy,
  output logic       wr_drop,
  output logic [2:0] ch,
  output logic [1:0] op,
  output logic [7:0] reg_din,
  output logic [5:0] latch_fnum,
  output logic       up_keyon,
  output logic       up_dt1,
  output logic       up_tl,
  output logic       up_ks_ar,
  output logic       up_amen_dr,
  output logic       up_sr,
  output logic       up_sl_rr,
  output logic       up_ssgeg,
  output logic       up_alg,
  output logic       up_fnumlo,
  output logic       up_pms
);

  localparam logic [4:0] ROUND_LAST = round_len(num_ch) - 5'd1;

  wr_state_e          state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [7:0]         sel_q, sel_d;
  logic               part_q, part_d;
  logic [NUM_STB-1:0] stb_q, stb_d;
  logic [2:0]         ch_q, ch_d;
  logic [1:0]         op_q, op_d;
  logic [7:0]         din_q, din_d;
  logic [5:0]         latch_q, latch_d;
  logic               drop_q, drop_d;

  logic [NUM_STB-1:0] dec_stb;
  logic [2:0]         dec_ch;
  logic [1:0]         dec_op;
  logic               dec_valid, dec_latch;
  logic               addr_wr, data_wr;

  assign addr_wr = write & ~addr[0];
  assign data_wr = write & addr[0];

  jt12_wr_dec #(
    .num_ch (num_ch)
  ) u_dec (
    .part  (part_q),
    .sel   (sel_q),
    .stb   (dec_stb),
    .ch    (dec_ch),
    .op    (dec_op),
    .valid (dec_valid),
    .latch (dec_latch)
  );

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    part_d  = part_q;
    stb_d   = stb_q;
    ch_d    = ch_q;
    op_d    = op_q;
    din_d   = din_q;
    latch_d = latch_q;
    drop_d  = 1'b0;

    // Address writes never touch the held request
    if (addr_wr) begin
      sel_d  = din;
      part_d = addr[1];
    end

    unique case (state_q)
      IDLE: begin
        if (data_wr) begin
          if (dec_valid) begin
            state_d = HOLD;
            cnt_d   = 5'd0;
            stb_d   = dec_stb;
            ch_d    = dec_ch;
            op_d    = dec_op;
            din_d   = din;
          end else if (dec_latch) begin
            latch_d = din[5:0];
          end
        end
      end
      HOLD: begin
        // Includes a write on the exit edge itself
        drop_d = data_wr;
        if (clk_en) begin
          if (cnt_q == ROUND_LAST) begin
            state_d = IDLE;
            stb_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sel_q   <= '0;
      part_q  <= 1'b0;
      stb_q   <= '0;
      ch_q    <= '0;
      op_q    <= '0;
      din_q   <= '0;
      latch_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      part_q  <= part_d;
      stb_q   <= stb_d;
      ch_q    <= ch_d;
      op_q    <= op_d;
      din_q   <= din_d;
      latch_q <= latch_d;
      drop_q  <= drop_d;
    end
  end

  assign busy       = (state_q == HOLD);
  assign wr_drop    = drop_q;
  assign ch         = ch_q;
  assign op         = op_q;
  assign reg_din    = din_q;
  assign latch_fnum = latch_q;
  assign up_keyon   = stb_q[STB_KEYON];
  assign up_dt1     = stb_q[STB_DT1];
  assign up_tl      = stb_q[STB_TL];
  assign up_ks_ar   = stb_q[STB_KS_AR];
  assign up_amen_dr = stb_q[STB_AMEN_DR];
  assign up_sr      = stb_q[STB_SR];
  assign up_sl_rr   = stb_q[STB_SL_RR];
  assign up_ssgeg   = stb_q[STB_SSGEG];
  assign up_alg     = stb_q[STB_ALG];
  assign up_fnumlo  = stb_q[STB_FNUMLO];
  assign up_pms     = stb_q[STB_PMS];

endmodule

// File: tb/tb_jt12_wr_sched.sv
// Bench for jt12_wr_sched: a 6-channel and a 3-channel instance share the
// same stimulus; a request-level model predicts both every cycle.
module tb_jt12_wr_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic [1:0] addr = 2'b00;
  logic [7:0] din = 8'h00;
  logic       write = 1'b0;

  logic       busy0, drop0, busy1, drop1;
  logic [2:0] ch0, ch1;
  logic [1:0] op0, op1;
  logic [7:0] rdin0, rdin1;
  logic [5:0] lf0, lf1;
  logic [10:0] stb0, stb1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Strobe vector order: keyon,dt1,tl,ks_ar,amen_dr,sr,sl_rr,ssgeg,alg,fnumlo,pms
  jt12_wr_sched #(.num_ch(6)) dut0 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .addr(addr), .din(din), .write(write),
    .busy(busy0), .wr_drop(drop0), .ch(ch0), .op(op0), .reg_din(rdin0), .latch_fnum(lf0),
    .up_keyon(stb0[0]), .up_dt1(stb0[1]), .up_tl(stb0[2]), .up_ks_ar(stb0[3]),
    .up_amen_dr(stb0[4]), .up_sr(stb0[5]), .up_sl_rr(stb0[6]), .up_ssgeg(stb0[7]),
    .up_alg(stb0[8]), .up_fnumlo(stb0[9]), .up_pms(stb0[10])
  );

  jt12_wr_sched #(.num_ch(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .addr(addr), .din(din), .write(write),
    .busy(busy1), .wr_drop(drop1), .ch(ch1), .op(op1), .reg_din(rdin1), .latch_fnum(lf1),
    .up_keyon(stb1[0]), .up_dt1(stb1[1]), .up_tl(stb1[2]), .up_ks_ar(stb1[3]),
    .up_amen_dr(stb1[4]), .up_sr(stb1[5]), .up_sl_rr(stb1[6]), .up_ssgeg(stb1[7]),
    .up_alg(stb1[8]), .up_fnumlo(stb1[9]), .up_pms(stb1[10])
  );

  // ---------------- model ----------------
  localparam int KIND_LATCH = 11;
  localparam int KIND_NONE  = 12;
  int   nch_of[2]   = '{6, 3};
  int   round_of[2] = '{24, 12};

  bit         m_busy[2]  = '{0, 0};
  int         m_rem[2]   = '{0, 0};
  int         m_kind[2]  = '{0, 0};
  logic [2:0] m_ch[2]    = '{0, 0};
  logic [1:0] m_op[2]    = '{0, 0};
  logic [7:0] m_din[2]   = '{0, 0};
  logic [5:0] m_latch[2] = '{0, 0};
  bit         m_drop[2]  = '{0, 0};
  logic [7:0] m_sel[2]   = '{0, 0};
  bit         m_part[2]  = '{0, 0};

  function automatic int decode(input logic [7:0] s, input bit p, input int nch);
    int v;
    v = int'(s);
    if (p && nch == 3) return KIND_NONE;
    if (v == 'h28) return p ? KIND_NONE : 0;
    if (v >= 'h30 && v <= 'h9F && (v % 4) != 3) return v / 16 - 2;
    if (v >= 'hA0 && v <= 'hA2) return 9;
    if (v >= 'hA4 && v <= 'hA6) return KIND_LATCH;
    if (v >= 'hB0 && v <= 'hB2) return 8;
    if (v >= 'hB4 && v <= 'hB6) return 10;
    return KIND_NONE;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 0; m_rem[i] = 0; m_kind[i] = 0; m_ch[i] = 0; m_op[i] = 0;
        m_din[i] = 0; m_latch[i] = 0; m_drop[i] = 0; m_sel[i] = 0; m_part[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit was;
        int k;
        was = m_busy[i];
        m_drop[i] = 0;
        if (was && clk_en) begin
          m_rem[i] = m_rem[i] - 1;
          if (m_rem[i] == 0) m_busy[i] = 0;
        end
        if (write && !addr[0]) begin
          m_sel[i] = din;
          m_part[i] = addr[1];
        end else if (write && addr[0]) begin
          if (was) m_drop[i] = 1;
          else begin
            k = decode(m_sel[i], m_part[i], nch_of[i]);
            if (k == KIND_LATCH) m_latch[i] = din[5:0];
            else if (k < KIND_LATCH) begin
              m_busy[i] = 1; m_rem[i] = round_of[i]; m_kind[i] = k;
              m_ch[i] = {m_part[i], m_sel[i][1:0]}; m_op[i] = m_sel[i][3:2];
              m_din[i] = din;
            end
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic b, input logic d, input logic [2:0] c,
                          input logic [1:0] o, input logic [7:0] r, input logic [5:0] l,
                          input logic [10:0] s);
    logic [10:0] es;
    es = m_busy[i] ? (11'd1 << m_kind[i]) : 11'd0;
    check($sformatf("m%0d_busy", i), 32'(b), 32'(m_busy[i]));
    check($sformatf("m%0d_drop", i), 32'(d), 32'(m_drop[i]));
    check($sformatf("m%0d_ch", i), 32'(c), 32'(m_ch[i]));
    check($sformatf("m%0d_op", i), 32'(o), 32'(m_op[i]));
    check($sformatf("m%0d_reg_din", i), 32'(r), 32'(m_din[i]));
    check($sformatf("m%0d_latch", i), 32'(l), 32'(m_latch[i]));
    check($sformatf("m%0d_strobes", i), 32'(s), 32'(es));
  endtask

  always @(negedge clk) begin
    cmp_inst(0, busy0, drop0, ch0, op0, rdin0, lf0, stb0);
    cmp_inst(1, busy1, drop1, ch1, op1, rdin1, lf1, stb1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr = a; din = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy0 || busy1) && k < 200) begin
      tick();
      k++;
    end
    check("idle_timeout", 32'(busy0 | busy1), 32'd0);
  endtask

  // Count busy cycles of instance 0 from the current one until it drops
  task automatic count_busy(input int start, output int n);
    n = start;
    while (busy0 && n < 100) begin
      tick();
      if (busy0) n++;
    end
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_strobes", 32'(stb0 | stb1), 32'd0);
    check("rst_regs", {ch0, op0, rdin0, lf0}, 32'd0);
    rst_n = 1'b1;
    tick();

    // TL write, part 0: ch 2, op 0
    wr(2'b00, 8'h42);
    wr(2'b01, 8'h7F);
    check("tl_strobe", 32'(stb0), 32'h004);
    check("tl_ch", 32'(ch0), 32'd2);
    check("tl_op", 32'(op0), 32'd0);
    check("tl_din", 32'(rdin0), 32'h7F);
    check("tl_busy3", 32'(busy1), 32'd1);
    count_busy(1, n);
    check("tl_round24", 32'(n), 32'd24);
    check("tl_after", {21'd0, stb0}, 32'd0);
    check("tl_kept", {ch0, rdin0}, {3'd2, 8'h7F});
    wait_idle();

    // DT1 on part 1: ch 5, op 3; 3-channel instance ignores it
    wr(2'b10, 8'h3D);
    wr(2'b11, 8'h15);
    check("dt1_strobe", 32'(stb0), 32'h002);
    check("dt1_chop", {ch0, op0}, {3'd5, 2'd3});
    check("dt1_busy3", 32'(busy1), 32'd0);
    wait_idle();

    // Write 5 clks into HOLD is dropped; round still 24
    wr(2'b00, 8'h42);
    wr(2'b01, 8'h11);
    n = 1;
    repeat (4) begin tick(); if (busy0) n++; end
    wr(2'b01, 8'h99);
    if (busy0) n++;
    check("drop_pulse", 32'(drop0), 32'd1);
    check("drop_kept", 32'(rdin0), 32'h11);
    tick();
    if (busy0) n++;
    check("drop_once", 32'(drop0), 32'd0);
    count_busy(n, n);
    check("drop_round24", 32'(n), 32'd24);
    wait_idle();

    // Write on the exact exit edge is dropped, next clk is accepted
    wr(2'b01, 8'h44);
    repeat (23) tick();
    wr(2'b01, 8'h55);
    check("exit_drop", {drop0, busy0}, 2'b10);
    wr(2'b01, 8'h66);
    check("exit_accept", {busy0, rdin0}, {1'b1, 8'h66});
    wait_idle();

    // Fnum-high latch: no strobe, no busy
    wr(2'b00, 8'hA5);
    wr(2'b01, 8'h23);
    check("latch_val", 32'(lf0), 32'h23);
    check("latch_nobusy", {busy0, stb0}, 32'd0);

    // Slot 3 address and part 1 on the 3-channel chip are ignored
    wr(2'b00, 8'h43);
    wr(2'b01, 8'hAA);
    check("slot3_ignore", {busy0, busy1, drop0, drop1}, 32'd0);
    wr(2'b10, 8'h30);
    wr(2'b11, 8'hAA);
    check("p1_nch3_ignore", {busy1, drop1, stb1}, 32'd0);
    check("p1_nch6_dt1", {busy0, ch0, stb0}, {1'b1, 3'd4, 11'h002});
    tick();
    check("p1_nodrop", 32'(drop1), 32'd0);
    wait_idle();

    // clk_en low freezes HOLD; latch write in HOLD is dropped
    wr(2'b00, 8'hB0);
    wr(2'b01, 8'h07);
    clk_en = 1'b0;
    repeat (30) tick();
    check("freeze_busy", {busy0, busy1, stb0}, {2'b11, 11'h100});
    clk_en = 1'b1;
    tick();
    clk_en = 1'b0;
    wr(2'b00, 8'hA4);
    wr(2'b01, 8'h3C);
    check("latch_in_hold", {drop0, lf0}, {1'b1, 6'h23});
    clk_en = 1'b1;
    wait_idle();

    // Async reset mid-HOLD, then a full round afterwards
    wr(2'b00, 8'h42);
    wr(2'b01, 8'h7F);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {busy0, busy1}, 32'd0);
    check("arst_strobes", 32'(stb0 | stb1), 32'd0);
    check("arst_regs", {ch0, op0, rdin0, lf0}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    wr(2'b00, 8'h42);
    wr(2'b01, 8'h5A);
    count_busy(1, n);
    check("post_rst_round24", 32'(n), 32'd24);
    wait_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
